// File: rtl/enabled_register_serializer_pkg.sv
// Shared types and constants for the enabled-register serializer slice.
// The FSM state encoding and default word width live here so every file agrees.
package enabled_reg_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam int DEFAULT_REG_WIDTH = 4;

  // Counter width for a word of the given width; never below one bit.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/enabled_register_serializer_if.sv
// Load-side and serial-side handshake bundle for the serializer.
// slave is the serializer's view, master is the view of whoever drives and consumes it.
interface enabled_register_serializer_if
  import enabled_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_REG_WIDTH
);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_data;
  logic             ser_last;
  logic             busy;

  modport slave (
    input  load_valid,
    input  load_data,
    input  ser_ready,
    output load_ready,
    output ser_valid,
    output ser_data,
    output ser_last,
    output busy
  );

  modport master (
    output load_valid,
    output load_data,
    output ser_ready,
    input  load_ready,
    input  ser_valid,
    input  ser_data,
    input  ser_last,
    input  busy
  );

endinterface

// File: rtl/enabled_register_serializer_ser_shift_reg.sv
// WIDTH-bit shift register with load-enable and shift-enable; load wins over shift.
// Shifting moves bits toward the output end and fills the vacated end with zero.
module ser_shift_reg
  import enabled_reg_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_REG_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             out_bit
);

  logic [WIDTH-1:0] shreg_reg;
  logic [WIDTH-1:0] shreg_next;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (MSB_FIRST) begin : g_msb
        if (gi == 0) begin : g_fill
          assign shreg_next[gi] = 1'b0;
        end else begin : g_move
          assign shreg_next[gi] = shreg_reg[gi-1];
        end
      end else begin : g_lsb
        if (gi == WIDTH - 1) begin : g_fill
          assign shreg_next[gi] = 1'b0;
        end else begin : g_move
          assign shreg_next[gi] = shreg_reg[gi+1];
        end
      end
    end

    if (MSB_FIRST) begin : g_out_msb
      assign out_bit = shreg_reg[WIDTH-1];
    end else begin : g_out_lsb
      assign out_bit = shreg_reg[0];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_reg <= '0;
    end else if (load_en) begin
      shreg_reg <= load_data;
    end else if (shift_en) begin
      shreg_reg <= shreg_next;
    end
  end

endmodule

// File: rtl/enabled_register_serializer.sv
// Parallel-to-serial converter: accepts a word on the load handshake and emits it
// one bit per accepted serial cycle, with back-to-back reload on the last bit.
module enabled_register_serializer
  import enabled_reg_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_REG_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  enabled_register_serializer_if.slave  bus
);

  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  ser_state_t       state_reg;
  logic [CNT_W-1:0] bit_cnt_reg;

  logic shifting;
  logic last_bit;
  logic ser_fire;
  logic load_fire;

  assign shifting  = (state_reg == SHIFT);
  assign last_bit  = shifting && (bit_cnt_reg == LAST_CNT);
  assign ser_fire  = shifting && bus.ser_ready;
  // Ready opens on the final transfer so a waiting word follows with no bubble.
  assign bus.load_ready = !shifting || (ser_fire && last_bit);
  assign load_fire      = bus.load_valid && bus.load_ready;

  assign bus.ser_valid = shifting;
  assign bus.busy      = shifting;
  assign bus.ser_last  = last_bit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.load_valid) begin
            state_reg   <= SHIFT;
            bit_cnt_reg <= '0;
          end
        end
        SHIFT: begin
          if (ser_fire) begin
            if (last_bit) begin
              bit_cnt_reg <= '0;
              state_reg   <= bus.load_valid ? SHIFT : IDLE;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg   <= IDLE;
          bit_cnt_reg <= '0;
        end
      endcase
    end
  end

  ser_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_en   (load_fire),
    .load_data (bus.load_data),
    .shift_en  (ser_fire),
    .out_bit   (bus.ser_data)
  );

endmodule

// File: tb/tb_enabled_register_serializer.sv
// Bench for enabled_register_serializer: MSB-first and LSB-first instances checked
// each cycle against a queue-of-expected-bits model.
module tb_enabled_register_serializer;
  import enabled_reg_pkg::*;

  logic clk;
  logic reset_n;

  enabled_register_serializer_if #(.WIDTH(4)) bus_m ();
  enabled_register_serializer_if #(.WIDTH(4)) bus_l ();

  enabled_register_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_m)
  );

  enabled_register_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Observed / expected vectors: {load_ready, ser_valid, ser_data, ser_last, busy}
  logic [4:0] obs;
  logic [4:0] exp_v;

  // Bits still owed by each DUT, front = bit currently on the wire.
  bit q_m[$];
  bit q_l[$];

  task automatic drive_cycle(input bit sel, input bit lv, input logic [3:0] ld, input bit sr);
    int n;
    bit v_e, d_e, last_e, lr_e;
    @(negedge clk);
    if (!sel) begin
      bus_m.load_valid = lv; bus_m.load_data = ld; bus_m.ser_ready = sr;
      bus_l.load_valid = 1'b0; bus_l.ser_ready = 1'b0;
    end else begin
      bus_l.load_valid = lv; bus_l.load_data = ld; bus_l.ser_ready = sr;
      bus_m.load_valid = 1'b0; bus_m.ser_ready = 1'b0;
    end
    #1;
    if (!sel) obs = {bus_m.load_ready, bus_m.ser_valid, bus_m.ser_data, bus_m.ser_last, bus_m.busy};
    else      obs = {bus_l.load_ready, bus_l.ser_valid, bus_l.ser_data, bus_l.ser_last, bus_l.busy};
    n      = sel ? q_l.size() : q_m.size();
    v_e    = (n > 0);
    d_e    = (n > 0) ? (sel ? q_l[0] : q_m[0]) : 1'b0;
    last_e = (n == 1);
    lr_e   = (n == 0) || (sr && n == 1);
    exp_v  = {lr_e, v_e, d_e, last_e, v_e};
    if (v_e && sr) begin
      if (sel) void'(q_l.pop_front()); else void'(q_m.pop_front());
    end
    if (lv && lr_e) begin
      if (sel) for (int i = 0; i < 4; i++) q_l.push_back(ld[i]);
      else     for (int i = 3; i >= 0; i--) q_m.push_back(ld[i]);
    end
    cyc++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus_m.load_valid = 1'b0; bus_m.load_data = '0; bus_m.ser_ready = 1'b0;
    bus_l.load_valid = 1'b0; bus_l.load_data = '0; bus_l.ser_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    obs = {bus_m.load_ready, bus_m.ser_valid, bus_m.ser_data, bus_m.ser_last, bus_m.busy};
    n_cmp++;
    if (obs !== 5'b10000) begin
      n_err++; $display("FAIL reset_msb: got %b want 10000 (lr,v,d,last,busy)", obs);
    end
    obs = {bus_l.load_ready, bus_l.ser_valid, bus_l.ser_data, bus_l.ser_last, bus_l.busy};
    n_cmp++;
    if (obs !== 5'b10000) begin
      n_err++; $display("FAIL reset_lsb: got %b want 10000 (lr,v,d,last,busy)", obs);
    end
    @(negedge clk);
    reset_n = 1'b1;
    $display("reset: outputs checked on both instances");
  endtask

  task automatic test_basic_msb();
    drive_cycle(0, 1, 4'b1011, 1);
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL basic_msb cyc%0d: got %b want %b", cyc, obs, exp_v);
      end
      drive_cycle(0, 0, 4'b0000, 1);
    end
    $display("basic_msb: word 1011 streamed");
  endtask

  task automatic test_basic_lsb();
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1, (i == 0), 4'b1011, 1);
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL basic_lsb cyc%0d: got %b want %b", cyc, obs, exp_v);
      end
    end
    $display("basic_lsb: word 1011 streamed");
  endtask

  task automatic test_backpressure();
    bit pat[7] = '{1, 0, 0, 1, 0, 1, 1};
    drive_cycle(0, 1, 4'b0110, 0);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL backpressure_load cyc%0d: got %b want %b", cyc, obs, exp_v);
    end
    for (int i = 0; i < 8; i++) begin
      drive_cycle(0, 0, 4'b0000, (i < 7) ? pat[i] : 1'b1);
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL backpressure cyc%0d: got %b want %b", cyc, obs, exp_v);
      end
    end
    $display("backpressure: word 0110 with stalls");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      drive_cycle(0, (i <= 4), (i < 4) ? 4'hA : 4'h5, 1);
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL back_to_back cyc%0d: got %b want %b", cyc, obs, exp_v);
      end
    end
    $display("back_to_back: words A then 5");
  endtask

  task automatic test_ignored_load();
    for (int i = 0; i < 10; i++) begin
      drive_cycle(0, (i <= 4), (i == 0) ? 4'h3 : 4'hF, 1);
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL ignored_load cyc%0d: got %b want %b", cyc, obs, exp_v);
      end
    end
    $display("ignored_load: 3 then F");
  endtask

  task automatic test_reset_mid_word();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, (i == 0), 4'b1011, 1);
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL midreset_pre cyc%0d: got %b want %b", cyc, obs, exp_v);
      end
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    obs = {bus_m.load_ready, bus_m.ser_valid, bus_m.ser_data, bus_m.ser_last, bus_m.busy};
    n_cmp++;
    if (obs !== 5'b10000) begin
      n_err++; $display("FAIL midreset_async: got %b want 10000", obs);
    end
    q_m.delete();
    q_l.delete();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(0, 0, 4'b0000, 1);
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL midreset_post cyc%0d: got %b want %b", cyc, obs, exp_v);
      end
    end
    $display("reset_mid_word: partial word discarded");
  endtask

  task automatic test_random();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 300; i++) begin
        drive_cycle(s[0], $urandom_range(0, 1), 4'($urandom), ($urandom_range(0, 3) != 0));
        n_cmp++;
        if (obs !== exp_v) begin
          n_err++; $display("FAIL random_%0d cyc%0d: got %b want %b", s, cyc, obs, exp_v);
        end
      end
      for (int i = 0; i < 6; i++) begin
        drive_cycle(s[0], 0, 4'b0000, 1);
        n_cmp++;
        if (obs !== exp_v) begin
          n_err++; $display("FAIL random_drain_%0d cyc%0d: got %b want %b", s, cyc, obs, exp_v);
        end
      end
      $display("random: instance %0d, 300 cycles", s);
    end
  endtask

  initial begin
    test_reset();
    test_basic_msb();
    test_basic_lsb();
    test_backpressure();
    test_back_to_back();
    test_ignored_load();
    test_reset_mid_word();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/enabled_register_serializer.md
Name: enabled_register_serializer

Overview:
- Reads a WIDTH-bit word out of an enabled-register stage and emits it one bit per accepted cycle on a serial port.
- Upstream side is a valid/ready load handshake, sourced by an enabled register's captured output.
- Downstream side is a valid/ready serial handshake with a last-bit marker.
- Sits between register banks and bit-serial links/debug taps; the read-direction counterpart of the enabled capture register.

Parameters:
- WIDTH, 4, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- reset_n  input  1  asynchronous, active-low reset.
- load_valid  input  1  load_data is valid.
- load_ready  output  1  block can accept a word this cycle.
- load_data  input  WIDTH  parallel word to serialize.
- ser_valid  output  1  ser_data is valid.
- ser_ready  input  1  downstream accepts ser_data this cycle.
- ser_data  output  1  current serial bit.
- ser_last  output  1  current bit is the final bit of the word.
- busy  output  1  a word is held and not yet fully sent.

Behaviour:
- Reset: asynchronous assertion while reset_n=0; release is synchronous to clk by the upstream reset synchronizer.
- All of the following are 0 in reset: state, shift register, bit counter, ser_valid, ser_data, ser_last, busy.
- load_ready is 1 in reset (state IDLE).
- FSM has two states, IDLE and SHIFT.
- IDLE:
  - load_ready=1, ser_valid=0, busy=0.
  - On load_valid&&load_ready: capture load_data into the shift register, clear bit_cnt to 0, go to SHIFT.
  - First bit is presented the next cycle, so load-to-first-bit latency is 1 clock.
- SHIFT:
  - ser_valid=1, busy=1.
  - ser_data = shreg[WIDTH-1] if MSB_FIRST, else shreg[0].
  - ser_last = (bit_cnt == WIDTH-1).
- Serial handshake:
  - A bit transfers when ser_valid&&ser_ready.
  - On transfer, shift toward the output end, fill with 0, and increment bit_cnt.
  - Without a transfer, ser_data, ser_last and bit_cnt hold. Stalls are unlimited and no bit is lost or duplicated.
- Last bit:
  - On transfer with ser_last=1: if load_valid is also 1, load the new word directly and stay in SHIFT (back-to-back, no idle bubble); otherwise go to IDLE.
  - load_ready = (state==IDLE) || (ser_valid && ser_ready && ser_last). This is combinational from ser_ready; no path from load_valid to load_ready.
- load_valid in SHIFT, outside the last-bit transfer: ignored. load_ready=0, so upstream must hold its word.
- Throughput: WIDTH bits per WIDTH cycles with ser_ready held at 1 and load_valid held at 1.
- bit_cnt width is $clog2(WIDTH). bit_cnt never exceeds WIDTH-1; it resets to 0 on every load.
- load_data is registered on accept; later changes to load_data do not affect the word in flight.
- Reset mid-word: the word is discarded, outputs return to reset values immediately, and no partial-word completion occurs after release.
- ser_ready=1 in IDLE has no effect.

Decomposition:
- Shared package enabled_reg_pkg:
  - state typedef ser_state_t {IDLE, SHIFT}.
  - Constant DEFAULT_REG_WIDTH=4.
- One natural sub-module: ser_shift_reg, a WIDTH-bit shift register with load-enable and shift-enable (enabled-register style) and an MSB_FIRST parameter. FSM and counter stay in the top module.

Test Plan:
- Reset check: reset_n=0 -> ser_valid=0, busy=0, load_ready=1, ser_data=0. Assert reset_n=0 mid-word (after 2 bits of 4'b1011) -> outputs return to reset values immediately; after release, no further bits.
- Basic, MSB_FIRST=1: load 4'b1011, ser_ready=1 -> ser_data 1,0,1,1 on 4 consecutive cycles starting 1 cycle after accept; ser_last=1 only on 4th bit; then IDLE.
- LSB first, MSB_FIRST=0: load 4'b1011 -> bits 1,1,0,1; ser_last on 4th bit.
- Backpressure: load 4'b0110, ser_ready pattern 1,0,0,1,0,1,1 -> bits 0,1,1,0 in order; ser_data/ser_last held during every ser_ready=0 cycle; load_ready=0 throughout until last transfer.
- Back-to-back: load_valid held 1 with words 4'hA then 4'h5, ser_ready=1 -> 8 contiguous valid bits 1,0,1,0,0,1,0,1; load_ready pulses on the 4th-bit cycle; no idle gap.
- Ignored load: present 4'hF while shifting 4'h3 mid-word -> stream 0,0,1,1 unchanged; 4'hF accepted only at the last-bit transfer.
